// File: rtl/jedro_1_data_ram_if.sv
`default_nettype none
// ============================================================================
// Module  : jedro_1_data_ram_if
// Brief   : Load/store request/grant/response bundle between core and data RAM.
// Revision: 1.0 - initial release
// ============================================================================
interface jedro_1_data_ram_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                    req_i;
   logic [ADDR_WIDTH-1:0]   addr_i;
   logic [DATA_WIDTH/8-1:0] we_i;
   logic [DATA_WIDTH-1:0]   wdata_i;
   logic                    gnt_o;
   logic                    rvalid_o;
   logic [DATA_WIDTH-1:0]   rdata_o;
   logic                    err_o;

   modport master (
      output req_i, addr_i, we_i, wdata_i,
      input  gnt_o, rvalid_o, rdata_o, err_o
   );

   modport slave (
      input  req_i, addr_i, we_i, wdata_i,
      output gnt_o, rvalid_o, rdata_o, err_o
   );
endinterface
`default_nettype wire

// File: rtl/jedro_1_data_ram.sv
`default_nettype none
// ============================================================================
// Module  : jedro_1_data_ram
// Brief   : Word RAM with byte-lane writes, programmable read latency and
//           error response, one outstanding request.
// Revision: 1.0 - initial release
// ============================================================================
module jedro_1_data_ram #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic               clk_i,
   input  logic               rst_i,
   jedro_1_data_ram_if.slave  bus
);
   localparam int                    c_lanes  = DATA_WIDTH / 8;
   localparam int                    c_iw     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [ADDR_WIDTH-1:0] c_depth  = ADDR_WIDTH'(DEPTH_WORDS);
   localparam logic [1:0]            c_lat_m1 = 2'(READ_LATENCY - 1);
   localparam logic [0:0]            c_st_idle = 1'b0;
   localparam logic [0:0]            c_st_busy = 1'b1;

   generate
      if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
         $error("jedro_1_data_ram: READ_LATENCY must be in 1..4");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];
   logic [0:0]            r_state;
   logic [1:0]            r_cnt;
   logic                  r_rvalid;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_pend_data;
   logic                  r_pend_err;

   logic                  w_gnt;
   logic                  w_accept;
   logic                  w_err;
   logic                  w_write;
   logic                  w_resp;
   logic [c_iw-1:0]       w_word;

   assign w_resp   = (r_state == c_st_busy) && (r_cnt == 2'd0);
   assign w_gnt    = (r_state == c_st_idle) || w_resp;
   assign w_accept = bus.req_i && w_gnt;
   assign w_word   = bus.addr_i[c_iw+1:2];
   assign w_write  = |bus.we_i;
   assign w_err    = (bus.addr_i[1:0] != 2'b00) ||
                     ({2'b00, bus.addr_i[ADDR_WIDTH-1:2]} >= c_depth);

   assign bus.gnt_o    = w_gnt;
   assign bus.rvalid_o = r_rvalid;
   assign bus.rdata_o  = r_rdata;
   assign bus.err_o    = r_err;

   // RAM is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i && w_accept && !w_err) begin
         for (int n = 0; n < c_lanes; n++) begin
            if (bus.we_i[n]) begin
               r_mem[w_word][8*n +: 8] <= bus.wdata_i[8*n +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= c_st_idle;
         r_cnt       <= 2'd0;
         r_rvalid    <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_pend_data <= '0;
         r_pend_err  <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         if (w_resp) begin
            r_rvalid <= 1'b1;
            r_rdata  <= r_pend_data;
            r_err    <= r_pend_err;
         end

         case (r_state)
            c_st_idle: begin
               if (w_accept) begin
                  r_state <= c_st_busy;
                  r_cnt   <= c_lat_m1;
               end
            end
            c_st_busy: begin
               if (r_cnt != 2'd0) begin
                  r_cnt <= r_cnt - 2'd1;
               end else if (w_accept) begin
                  r_cnt <= c_lat_m1;
               end else begin
                  r_state <= c_st_idle;
               end
            end
            default: begin
               r_state <= c_st_idle;
               r_cnt   <= 2'd0;
            end
         endcase

         // Read data is captured at accept so a later write cannot alter it.
         if (w_accept) begin
            r_pend_err  <= w_err;
            r_pend_data <= (w_err || w_write) ? '0 : r_mem[w_word];
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_jedro_1_data_ram.sv
`default_nettype none
// ============================================================================
// Module  : tb_jedro_1_data_ram
// Brief   : Directed bench for jedro_1_data_ram at read latencies 1 and 3.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jedro_1_data_ram;
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        sel;
   logic [31:0] addr;
   logic [3:0]  we;
   logic [31:0] wdata;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   jedro_1_data_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();
   jedro_1_data_ram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b3 ();

   assign b1.req_i   = req & ~sel;
   assign b1.addr_i  = addr;
   assign b1.we_i    = we;
   assign b1.wdata_i = wdata;
   assign b3.req_i   = req & sel;
   assign b3.addr_i  = addr;
   assign b3.we_i    = we;
   assign b3.wdata_i = wdata;

   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   assign gnt    = sel ? b3.gnt_o    : b1.gnt_o;
   assign rvalid = sel ? b3.rvalid_o : b1.rvalid_o;
   assign rdata  = sel ? b3.rdata_o  : b1.rdata_o;
   assign err    = sel ? b3.err_o    : b1.err_o;

   jedro_1_data_ram #(.READ_LATENCY(1)) u_dut1 (.clk_i(clk), .rst_i(rst), .bus(b1));
   jedro_1_data_ram #(.READ_LATENCY(3)) u_dut3 (.clk_i(clk), .rst_i(rst), .bus(b3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single access; lat comes back as 99 when grant or response never arrives.
   task automatic access(input bit s, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] d, output logic [31:0] rd,
                         output logic e, output int lat);
      sel = s; addr = a; we = w; wdata = d; req = 1'b1;
      lat = 99; rd = 'x; e = 1'bx;
      for (int i = 0; i < 10 && !gnt; i++) tick();
      if (!gnt) begin
         req = 1'b0;
         return;
      end
      tick();
      req = 1'b0; we = 4'h0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (rvalid) begin
            lat = i; rd = rdata; e = err;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req = 1'b0; sel = 1'b0; addr = '0; we = '0; wdata = '0;
      repeat (3) tick();
      total += 8;
      if (b1.gnt_o !== 1'b1)    begin bad++; $display("FAIL rst_gnt1 got=%b want=1", b1.gnt_o); end
      if (b1.rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid1 got=%b want=0", b1.rvalid_o); end
      if (b1.rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata1 got=%h want=0", b1.rdata_o); end
      if (b1.err_o !== 1'b0)    begin bad++; $display("FAIL rst_err1 got=%b want=0", b1.err_o); end
      if (b3.gnt_o !== 1'b1)    begin bad++; $display("FAIL rst_gnt3 got=%b want=1", b3.gnt_o); end
      if (b3.rvalid_o !== 1'b0) begin bad++; $display("FAIL rst_rvalid3 got=%b want=0", b3.rvalid_o); end
      if (b3.rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata3 got=%h want=0", b3.rdata_o); end
      if (b3.err_o !== 1'b0)    begin bad++; $display("FAIL rst_err3 got=%b want=0", b3.err_o); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_write_read(input bit s);
      logic [31:0] rd; logic e; int lat; int exp_lat;
      exp_lat = s ? 3 : 1;
      access(s, 32'h10, 4'hF, 32'hDEADBEEF, rd, e, lat);
      total += 3;
      if (lat !== exp_lat) begin bad++; $display("FAIL wr_lat sel=%0d got=%0d want=%0d", s, lat, exp_lat); end
      if (e !== 1'b0)      begin bad++; $display("FAIL wr_err sel=%0d got=%b want=0", s, e); end
      if (rd !== 32'h0)    begin bad++; $display("FAIL wr_rdata sel=%0d got=%h want=0", s, rd); end
      access(s, 32'h10, 4'h0, 32'h0, rd, e, lat);
      total += 3;
      if (lat !== exp_lat)     begin bad++; $display("FAIL rd_lat sel=%0d got=%0d want=%0d", s, lat, exp_lat); end
      if (e !== 1'b0)          begin bad++; $display("FAIL rd_err sel=%0d got=%b want=0", s, e); end
      if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data sel=%0d got=%h want=deadbeef", s, rd); end
      tick();
      total += 2;
      if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_one_cycle sel=%0d got=%b want=0", s, rvalid); end
      if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold sel=%0d got=%h want=deadbeef", s, rdata); end
   endtask

   task automatic test_byte_lanes();
      logic [31:0] rd; logic e; int lat;
      access(1'b1, 32'h20, 4'hF, 32'h11223344, rd, e, lat);
      access(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, rd, e, lat);
      access(1'b1, 32'h20, 4'h0, 32'h0, rd, e, lat);
      total += 2;
      if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL lanes_data got=%h want=11bb33dd", rd); end
      if (e !== 1'b0)          begin bad++; $display("FAIL lanes_err got=%b want=0", e); end
   endtask

   task automatic test_errors();
      logic [31:0] rd; logic e; int lat;
      access(1'b1, 32'h13, 4'h0, 32'h0, rd, e, lat);
      total += 3;
      if (lat !== 3)     begin bad++; $display("FAIL mis_lat got=%0d want=3", lat); end
      if (e !== 1'b1)    begin bad++; $display("FAIL mis_err got=%b want=1", e); end
      if (rd !== 32'h0)  begin bad++; $display("FAIL mis_rdata got=%h want=0", rd); end
      access(1'b1, 32'd4096, 4'h0, 32'h0, rd, e, lat);
      total += 2;
      if (e !== 1'b1)    begin bad++; $display("FAIL oor_err got=%b want=1", e); end
      if (rd !== 32'h0)  begin bad++; $display("FAIL oor_rdata got=%h want=0", rd); end
      access(1'b1, 32'd4092, 4'h0, 32'h0, rd, e, lat);
      total += 1;
      if (e !== 1'b0)    begin bad++; $display("FAIL last_word_err got=%b want=0", e); end
      access(1'b1, 32'h22, 4'hF, 32'hFFFFFFFF, rd, e, lat);
      total += 1;
      if (e !== 1'b1)    begin bad++; $display("FAIL miswr_err got=%b want=1", e); end
      access(1'b1, 32'h20, 4'h0, 32'h0, rd, e, lat);
      total += 2;
      if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL miswr_keep got=%h want=11bb33dd", rd); end
      if (e !== 1'b0)          begin bad++; $display("FAIL miswr_keep_err got=%b want=0", e); end
   endtask

   task automatic test_back_to_back(input bit s);
      logic [31:0] rd; logic e; int l; int lat;
      int acc_cyc[8];
      int n_acc, n_rsp, extra;
      bit acc_now;
      lat = s ? 3 : 1;
      for (int i = 0; i < 8; i++)
         access(s, 32'h40 + 32'(4*i), 4'hF, 32'h1000_0000 + 32'(i) * 32'h0101, rd, e, l);
      sel = s; addr = 32'h40; we = 4'h0; req = 1'b1;
      n_acc = 0; n_rsp = 0;
      for (int cyc = 0; cyc < 60 && n_rsp < 8; cyc++) begin
         acc_now = req && gnt;
         tick();
         if (rvalid) begin
            total += 2;
            if (n_rsp >= n_acc) begin
               bad++; $display("FAIL b2b_spurious sel=%0d rsp=%0d acc=%0d", s, n_rsp, n_acc);
            end else begin
               if (rdata !== 32'h1000_0000 + 32'(n_rsp) * 32'h0101) begin
                  bad++; $display("FAIL b2b_data sel=%0d idx=%0d got=%h want=%h", s, n_rsp, rdata,
                                  32'h1000_0000 + 32'(n_rsp) * 32'h0101);
               end
               if (cyc - acc_cyc[n_rsp] != lat) begin
                  bad++; $display("FAIL b2b_lat sel=%0d idx=%0d got=%0d want=%0d", s, n_rsp,
                                  cyc - acc_cyc[n_rsp], lat);
               end
            end
            n_rsp++;
         end
         if (acc_now) begin
            acc_cyc[n_acc] = cyc;
            if (n_acc > 0) begin
               total++;
               if (cyc - acc_cyc[n_acc-1] != lat) begin
                  bad++; $display("FAIL b2b_spacing sel=%0d idx=%0d got=%0d want=%0d", s, n_acc,
                                  cyc - acc_cyc[n_acc-1], lat);
               end
            end
            n_acc++;
            if (n_acc == 8) req = 1'b0;
            else addr = 32'h40 + 32'(4*n_acc);
         end
      end
      req = 1'b0;
      extra = 0;
      repeat (6) begin
         tick();
         if (rvalid) extra++;
      end
      total += 3;
      if (n_acc != 8) begin bad++; $display("FAIL b2b_accepts sel=%0d got=%0d want=8", s, n_acc); end
      if (n_rsp != 8) begin bad++; $display("FAIL b2b_responses sel=%0d got=%0d want=8", s, n_rsp); end
      if (extra != 0) begin bad++; $display("FAIL b2b_extra sel=%0d got=%0d want=0", s, extra); end
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] rd; logic e; int lat; int seen;
      sel = 1'b1; addr = 32'h10; we = 4'h0; req = 1'b1;
      tick();
      req = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      total += 2;
      if (b3.rvalid_o !== 1'b0) begin bad++; $display("FAIL midrst_rvalid got=%b want=0", b3.rvalid_o); end
      if (b3.gnt_o !== 1'b1)    begin bad++; $display("FAIL midrst_gnt got=%b want=1", b3.gnt_o); end
      // A write presented while reset is high must not land in the RAM.
      addr = 32'h10; we = 4'hF; wdata = 32'h0; req = 1'b1;
      tick();
      req = 1'b0; we = 4'h0;
      rst = 1'b0;
      seen = 0;
      repeat (6) begin
         tick();
         if (b3.rvalid_o) seen++;
      end
      total += 1;
      if (seen != 0) begin bad++; $display("FAIL midrst_stale got=%0d want=0", seen); end
      access(1'b1, 32'h10, 4'h0, 32'h0, rd, e, lat);
      total += 2;
      if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL midrst_keep10 got=%h want=deadbeef", rd); end
      if (lat !== 3)           begin bad++; $display("FAIL midrst_lat got=%0d want=3", lat); end
      access(1'b1, 32'h20, 4'h0, 32'h0, rd, e, lat);
      total += 1;
      if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL midrst_keep20 got=%h want=11bb33dd", rd); end
   endtask

   initial begin
      test_reset();
      test_write_read(1'b0);
      test_write_read(1'b1);
      test_byte_lanes();
      test_errors();
      test_back_to_back(1'b0);
      test_back_to_back(1'b1);
      test_reset_mid_read();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
